cpu_rom_loader: RTL

Upstream feeder for the Chip-8 CPU memory write port. It accepts a game image as a byte stream (valid/ready/last) from the host/OSD side and writes it sequentially into program space starting at 0x200, holding the CPU in reset while loading. After the load it reads the image back through the same port and verifies an 8-bit additive checksum. It then releases the CPU and reports status.

---
 rtl/cpu_rom_loader.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_rom_loader.sv
// cpu_rom_loader: streams a Chip-8 game image into program memory starting at
// BASE_ADDR. The CPU is held in reset while the image loads. The image is then
// read back and checked against an 8-bit additive checksum. At the end the CPU
// is released and a status code is reported.
module cpu_rom_loader #(
    parameter logic [11:0] BASE_ADDR = 12'h200,
    parameter logic [11:0] END_ADDR  = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        mem_en,
    output logic        mem_write,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [11:0] load_len
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_VERIFY = 3'd2,
        S_VDRAIN = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] ST_OK    = 2'd0;
    localparam logic [1:0] ST_OVF   = 2'd1;
    localparam logic [1:0] ST_CSUM  = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    state_t      state, state_nxt;
    logic [11:0] ptr, ptr_nxt;
    logic [11:0] count, count_nxt;
    logic [7:0]  sum_w, sum_w_nxt;
    logic [7:0]  sum_r, sum_r_nxt;
    logic        rd_vld_p0;
    logic        mem_en_nxt, mem_write_nxt;
    logic [11:0] mem_addr_nxt;
    logic [7:0]  mem_wdata_nxt;
    logic        cpu_hold_nxt, done_nxt;
    logic [1:0]  status_nxt;
    logic [11:0] load_len_nxt;

    logic hs;
    logic load_exit;
    logic rd_last;
    logic rd_busy;

    assign s_ready   = (state == S_LOAD);
    assign busy      = (state == S_LOAD) || (state == S_VERIFY) || (state == S_VDRAIN);
    assign hs        = s_valid && s_ready;
    // The image ends on s_last or when the byte for the last writable address is taken.
    assign load_exit = hs && (s_last || (ptr == END_ADDR));
    assign rd_last   = (count == (load_len - 12'd1));
    // A read is still in flight while it is on the port or its data is returning.
    assign rd_busy   = (mem_en && !mem_write) || rd_vld_p0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_nxt = S_DONE;
                end else if (load_exit) begin
                    state_nxt = S_VERIFY;
                end
            end
            S_VERIFY: begin
                if (abort) begin
                    state_nxt = S_DONE;
                end else if (rd_last) begin
                    state_nxt = S_VDRAIN;
                end
            end
            S_VDRAIN: begin
                if (abort || !rd_busy) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the memory port, pointers, checksums and status outputs
    always_comb begin
        ptr_nxt       = ptr;
        count_nxt     = count;
        sum_w_nxt     = sum_w;
        sum_r_nxt     = rd_vld_p0 ? (sum_r + mem_rdata) : sum_r;
        mem_en_nxt    = 1'b0;
        mem_write_nxt = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        cpu_hold_nxt  = cpu_hold;
        done_nxt      = done;
        status_nxt    = status;
        load_len_nxt  = load_len;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ptr_nxt      = BASE_ADDR;
                    count_nxt    = '0;
                    sum_w_nxt    = '0;
                    sum_r_nxt    = '0;
                    done_nxt     = 1'b0;
                    status_nxt   = ST_OK;
                    cpu_hold_nxt = 1'b1;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    // An accepted byte is written even if abort arrives in the same cycle.
                    mem_en_nxt    = 1'b1;
                    mem_write_nxt = 1'b1;
                    mem_addr_nxt  = ptr;
                    mem_wdata_nxt = s_data;
                    ptr_nxt       = ptr + 12'd1;
                    count_nxt     = count + 12'd1;
                    sum_w_nxt     = sum_w + s_data;
                    if (load_exit || abort) begin
                        load_len_nxt = count + 12'd1;
                    end
                    if (load_exit && !s_last) begin
                        status_nxt = ST_OVF;
                    end
                    if (load_exit) begin
                        ptr_nxt   = BASE_ADDR;
                        count_nxt = '0;
                    end
                end else if (abort) begin
                    load_len_nxt = count;
                end
            end
            S_VERIFY: begin
                if (!abort) begin
                    mem_en_nxt   = 1'b1;
                    mem_addr_nxt = ptr;
                    ptr_nxt      = ptr + 12'd1;
                    count_nxt    = count + 12'd1;
                end
            end
            S_VDRAIN: begin
                if (!rd_busy && (status == ST_OK) && (sum_r != sum_w)) begin
                    status_nxt = ST_CSUM;
                end
            end
            default: ;
        endcase
        if ((state_nxt == S_DONE) && (state != S_DONE)) begin
            cpu_hold_nxt = 1'b0;
            done_nxt     = 1'b1;
            if (abort) begin
                status_nxt = ST_ABORT;
            end
        end
    end

    // Registered outputs and datapath state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            count     <= '0;
            sum_w     <= '0;
            sum_r     <= '0;
            rd_vld_p0 <= 1'b0;
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            status    <= ST_OK;
            load_len  <= '0;
        end else begin
            ptr       <= ptr_nxt;
            count     <= count_nxt;
            sum_w     <= sum_w_nxt;
            sum_r     <= sum_r_nxt;
            rd_vld_p0 <= mem_en && !mem_write;
            mem_en    <= mem_en_nxt;
            mem_write <= mem_write_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            cpu_hold  <= cpu_hold_nxt;
            done      <= done_nxt;
            status    <= status_nxt;
            load_len  <= load_len_nxt;
        end
    end

endmodule
